// File: rtl/mips_define_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   PC_*          : pc_src codes carried by a resolving branch/jump
//   fetch_state_e : instruction-fetch FSM states
//   fetch_ent_t   : one buffered instruction (pc + word)
//   branch_target : pc4 + sign-extended word offset
package mips_define;

  localparam logic [2:0] PC_NEXT = 3'd0;
  localparam logic [2:0] PC_JUMP = 3'd1;
  localparam logic [2:0] PC_JR   = 3'd2;
  localparam logic [2:0] PC_BEQ  = 3'd3;
  localparam logic [2:0] PC_BNE  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request outstanding
    S_WAIT = 2'd1,  // request outstanding, response wanted
    S_DROP = 2'd2   // request outstanding, response to be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Redirect target calculation (combinational).
//   src      : pc_src code of the resolving instruction
//   pc4      : its PC+4
//   imm      : branch offset field
//   index    : jump index field
//   rs_data  : rs value (JR)
//   zero     : rs == rt
//   target   : next fetch PC
//   misalign : JR target had low address bits set
module mips_next_pc
  import mips_define::*;
(
  input  logic [2:0]  src,
  input  logic [31:0] pc4,
  input  logic [15:0] imm,
  input  logic [25:0] index,
  input  logic [31:0] rs_data,
  input  logic        zero,
  output logic [31:0] target,
  output logic        misalign
);

  always_comb begin
    target   = pc4;
    misalign = 1'b0;
    case (src)
      PC_JUMP: target = {pc4[31:28], index, 2'b00};
      PC_JR: begin
        // low bits are forced to zero so fetch stays word aligned
        target   = {rs_data[31:2], 2'b00};
        misalign = |rs_data[1:0];
      end
      PC_BEQ:  if (zero)  target = branch_target(pc4, imm);
      PC_BNE:  if (!zero) target = branch_target(pc4, imm);
      default: target = pc4;
    endcase
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns fetch PC, runs the imem req/ready
// handshake and buffers up to two instructions (output reg + skid).
//   clk, rst              : clock, sync active-high reset
//   if_rst, if_en         : controller flush / ID consume
//   redir_*               : branch/jump redirect from the resolving stage
//   imem_req/addr         : memory request (addr held until ready)
//   imem_ready/rdata      : one-cycle response
//   inst, pc, if_valid    : instruction presented to ID
//   misalign              : one-cycle pulse for a misaligned JR target
module mips_fetch_unit
  import mips_define::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        redir_valid,
  input  logic [2:0]  redir_src,
  input  logic [31:0] redir_pc4,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_index,
  input  logic [31:0] redir_rs_data,
  input  logic        redir_zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        misalign
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  fetch_ent_t   skid;
  logic         skid_valid;

  logic [31:0]  tgt;
  logic         tgt_mis;

  mips_next_pc u_next_pc (
    .src      (redir_src),
    .pc4      (redir_pc4),
    .imm      (redir_imm),
    .index    (redir_index),
    .rs_data  (redir_rs_data),
    .zero     (redir_zero),
    .target   (tgt),
    .misalign (tgt_mis)
  );

  // if_rst behaves as a redirect to RESET_PC so an in-flight response
  // is still drained through S_DROP.
  logic        flush;
  logic [31:0] flush_pc;
  logic        consume;
  logic        out_free;
  logic        take;

  assign flush    = if_rst | redir_valid;
  assign flush_pc = if_rst ? RESET_PC : tgt;
  assign consume  = if_en & if_valid;
  assign out_free = ~if_valid | if_en;
  assign take     = (state == S_WAIT) & imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst       <= '0;
      pc         <= '0;
      if_valid   <= 1'b0;
      misalign   <= 1'b0;
      skid       <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
      fetch_pc   <= flush_pc;
      misalign   <= ~if_rst & tgt_mis;
      if (state != S_IDLE && !imem_ready) begin
        // request still in flight: keep req/addr stable, drop its data
        state <= S_DROP;
      end else begin
        state     <= S_WAIT;
        imem_req  <= 1'b1;
        imem_addr <= flush_pc;
      end
    end else begin
      misalign <= 1'b0;
      // skid is only ever full while idle, so it never races a response
      if (consume) begin
        if (skid_valid) begin
          inst       <= skid.inst;
          pc         <= skid.pc;
          skid_valid <= 1'b0;
        end else if (!take) begin
          if_valid <= 1'b0;
        end
      end
      case (state)
        S_IDLE: if (!skid_valid) begin
          state     <= S_WAIT;
          imem_req  <= 1'b1;
          imem_addr <= fetch_pc;
        end
        S_WAIT: if (imem_ready) begin
          fetch_pc <= imem_addr + 32'd4;
          if (out_free) begin
            inst      <= imem_rdata;
            pc        <= imem_addr;
            if_valid  <= 1'b1;
            imem_addr <= imem_addr + 32'd4;
          end else begin
            skid.inst  <= imem_rdata;
            skid.pc    <= imem_addr;
            skid_valid <= 1'b1;
            state      <= S_IDLE;
            imem_req   <= 1'b0;
          end
        end
        S_DROP: if (imem_ready) begin
          state     <= S_WAIT;
          imem_addr <= fetch_pc;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;
  import mips_define::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_rst, if_en, redir_valid, redir_zero;
  logic [2:0]  redir_src;
  logic [31:0] redir_pc4, redir_rs_data;
  logic [15:0] redir_imm;
  logic [25:0] redir_index;
  logic        imem_req, imem_ready, if_valid, misalign;
  logic [31:0] imem_addr, imem_rdata, inst, pc;

  mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .if_rst(if_rst), .if_en(if_en),
    .redir_valid(redir_valid), .redir_src(redir_src), .redir_pc4(redir_pc4),
    .redir_imm(redir_imm), .redir_index(redir_index),
    .redir_rs_data(redir_rs_data), .redir_zero(redir_zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst(inst), .pc(pc), .if_valid(if_valid),
    .misalign(misalign)
  );

  int tests = 0, fails = 0;

  // stimulus shadow, applied to the DUT at the negedge inside drive()
  logic        s_rst, s_if_rst, s_if_en, s_rv, s_zero;
  logic [2:0]  s_src;
  logic [31:0] s_pc4, s_rs;
  logic [15:0] s_imm;
  logic [25:0] s_idx;

  // memory: ready after mem_lat cycles of a request (0 = random 1..4)
  int mem_cnt = 0, mem_lat = 1, lat_mode = 1;
  bit data_is_addr = 1'b1;

  // reference model: FIFO of at most two fetched words + one request
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  bit          m_req, m_drop, m_mis;
  logic [31:0] m_addr, m_next;

  logic        o_req, o_valid, o_mis;
  logic [31:0] o_addr, o_pc, o_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [2:0] src, input logic [31:0] pc4,
      input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs, input logic z);
    int off;
    off = int'($signed(imm)) * 4;
    case (src)
      3'd1: return (pc4 & 32'hF000_0000) | (32'(idx) << 2);
      3'd2: return rs & ~32'h3;
      3'd3: return z ? pc4 + 32'(off) : pc4;
      3'd4: return !z ? pc4 + 32'(off) : pc4;
      default: return pc4;
    endcase
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_req = 0; m_drop = 0; m_mis = 0;
    m_addr = RESET_PC; m_next = RESET_PC;
  endtask

  task automatic sample();
    @(negedge clk);
    o_req = imem_req; o_addr = imem_addr; o_valid = if_valid;
    o_pc = pc; o_inst = inst; o_mis = misalign;
    chk("imem_req", o_req, m_req);
    if (m_req) chk("imem_addr", o_addr, m_addr);
    chk("if_valid", o_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("pc", o_pc, m_q[0].pc);
      chk("inst", o_inst, m_q[0].inst);
    end
    chk("misalign", o_mis, m_mis);
  endtask

  task automatic drive();
    logic rdy;
    logic [31:0] rd, tgt;
    int pre;
    rd = data_is_addr ? imem_addr : $urandom;
    rdy = 1'b0;
    if (s_rst) mem_cnt = 0;
    else if (imem_req) begin
      mem_cnt++;
      if (mem_cnt == 1) mem_lat = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
      if (mem_cnt >= mem_lat) begin rdy = 1'b1; mem_cnt = 0; end
    end else mem_cnt = 0;
    rst = s_rst; if_rst = s_if_rst; if_en = s_if_en; redir_valid = s_rv;
    redir_src = s_src; redir_pc4 = s_pc4; redir_imm = s_imm; redir_index = s_idx;
    redir_rs_data = s_rs; redir_zero = s_zero;
    imem_ready = rdy; imem_rdata = rd;
    // advance the model to what the next clock edge must produce
    if (s_rst) m_reset();
    else if (s_if_rst || s_rv) begin
      tgt = s_if_rst ? RESET_PC : ref_target(s_src, s_pc4, s_imm, s_idx, s_rs, s_zero);
      m_mis = !s_if_rst && s_src == 3'd2 && s_rs[1:0] != 2'b00;
      m_q.delete();
      m_next = tgt;
      if (m_req && !rdy) m_drop = 1;
      else begin m_req = 1; m_addr = tgt; m_drop = 0; end
    end else begin
      m_mis = 0;
      pre = m_q.size();
      if (s_if_en && pre > 0) void'(m_q.pop_front());
      if (m_req && rdy) begin
        if (m_drop) begin m_drop = 0; m_addr = m_next; end
        else begin
          m_q.push_back('{pc: m_addr, inst: rd});
          m_next = m_addr + 4;
          if (m_q.size() == 2) m_req = 0;
          else m_addr = m_addr + 4;
        end
      end else if (!m_req && pre < 2) begin
        m_req = 1; m_addr = m_next;
      end
    end
  endtask

  task automatic step();
    sample();
    drive();
  endtask

  // leaves the bench sampled but not yet driven, on a fresh request cycle
  task automatic run_until_fresh(input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (o_req && mem_cnt == 0) begin hit = 1; break; end
      drive();
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL %s: no fresh request within 40 cycles", name);
      sample();
    end
  endtask

  task automatic step_until_valid(input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_valid) begin hit = 1; break; end
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL %s: if_valid not seen within 40 cycles", name);
    end
  endtask

  initial begin
    s_rst = 1; s_if_rst = 0; s_if_en = 1; s_rv = 0; s_zero = 0;
    s_src = '0; s_pc4 = '0; s_rs = '0; s_imm = '0; s_idx = '0;
    rst = 1; if_rst = 0; if_en = 1; redir_valid = 0; redir_zero = 0;
    redir_src = '0; redir_pc4 = '0; redir_rs_data = '0; redir_imm = '0; redir_index = '0;
    imem_ready = 0; imem_rdata = '0;
    m_reset();

    // reset state
    repeat (3) step();
    chk("rst imem_req", o_req, 1'b0);
    chk("rst imem_addr", o_addr, RESET_PC);
    chk("rst if_valid", o_valid, 1'b0);
    chk("rst misalign", o_mis, 1'b0);

    // 1: streaming from reset with a 1-cycle memory returning addr
    s_rst = 0;
    step();
    step(); chk("t1 req", o_req, 1'b1); chk("t1 addr0", o_addr, 32'h0); chk("t1 nv", o_valid, 1'b0);
    step(); chk("t1 v", o_valid, 1'b1); chk("t1 pc0", o_pc, 32'h0); chk("t1 addr4", o_addr, 32'h4);
    step(); chk("t1 pc4", o_pc, 32'h4); chk("t1 inst4", o_inst, 32'h4);

    // 2: stall ID for 4 cycles
    s_if_en = 0;
    step(); chk("t2 pc8", o_pc, 32'h8);
    step(); chk("t2 hold", o_pc, 32'h8); chk("t2 req off", o_req, 1'b0);
    step();
    step(); chk("t2 hold2", o_pc, 32'h8); chk("t2 req off2", o_req, 1'b0);
    s_if_en = 1;
    step();
    step(); chk("t2 pc12", o_pc, 32'hC); chk("t2 v12", o_valid, 1'b1);
    step(); chk("t2 addr16", o_addr, 32'h10);
    step(); chk("t2 pc16", o_pc, 32'h10);

    // 3: BEQ taken while the response is still pending
    lat_mode = 3; data_is_addr = 0;
    run_until_fresh("t3 pre");
    s_rv = 1; s_src = 3'd3; s_pc4 = 32'h100; s_imm = 16'hFFFE; s_zero = 1;
    drive();
    s_rv = 0;
    step(); chk("t3 flushed", o_valid, 1'b0);
    run_until_fresh("t3 refetch");
    chk("t3 addr F8", o_addr, 32'hF8);
    drive();
    step_until_valid("t3 valid");
    chk("t3 pc F8", o_pc, 32'hF8);

    // 4: misaligned JR coinciding with imem_ready
    lat_mode = 1;
    run_until_fresh("t4 pre");
    s_rv = 1; s_src = 3'd2; s_rs = 32'h203;
    drive();
    s_rv = 0;
    step(); chk("t4 misalign", o_mis, 1'b1); chk("t4 addr", o_addr, 32'h200);
    chk("t4 req", o_req, 1'b1); chk("t4 nv", o_valid, 1'b0);
    step(); chk("t4 misalign off", o_mis, 1'b0);

    // 5: JUMP then BNE not taken
    run_until_fresh("t5 jump");
    s_rv = 1; s_src = 3'd1; s_pc4 = 32'h4000_0010; s_idx = 26'h10;
    drive();
    s_rv = 0;
    step(); chk("t5 jump addr", o_addr, 32'h4000_0040);
    run_until_fresh("t5 bne");
    s_rv = 1; s_src = 3'd4; s_pc4 = 32'h20; s_imm = 16'h0005; s_zero = 1;
    drive();
    s_rv = 0;
    step(); chk("t5 bne addr", o_addr, 32'h20);

    // 6: if_rst mid-request with a 3-cycle memory
    lat_mode = 3;
    run_until_fresh("t6 pre");
    s_if_rst = 1;
    drive();
    s_if_rst = 0;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 20; i++) begin
        sample();
        chk("t6 if_valid", o_valid, 1'b0);
        if (o_req && mem_cnt == 0) begin hit = 1; break; end
        drive();
      end
      if (hit) chk("t6 restart addr", o_addr, RESET_PC);
      else begin tests++; fails++; $display("FAIL t6 restart: no request within 20 cycles"); sample(); end
      drive();
    end

    // random traffic against the model
    lat_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      s_if_en  = ($urandom % 10) < 7;
      s_rv     = ($urandom % 20) == 0;
      s_src    = 3'($urandom_range(0, 7));
      s_pc4    = $urandom;
      s_imm    = 16'($urandom);
      s_idx    = 26'($urandom);
      s_rs     = $urandom;
      s_zero   = 1'($urandom);
      s_if_rst = ($urandom % 50) == 0;
      s_rst    = ($urandom % 200) == 0;
      step();
    end
    s_rv = 0; s_if_rst = 0; s_rst = 0; s_if_en = 1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
